sqrt_mem_engine: RTL and testbench

Sequential integer square-root engine attached to the byte-wide data memory alongside the CPU's program-3 path. On the Start/Ack handshake it reads a 16-bit operand from two data-memory bytes, computes its 8-bit integer square root bit by bit, writes the root back to data memory, and raises Ack. It gives verification a hardware golden path for program 3, using the same memory map (operand at 16/17, result at 18) and the same handshake as the CPU.

---
 rtl/sqrt_mem_engine.sv | 216 +++++++++++++++++++++
 tb/tb_sqrt_mem_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_mem_engine.sv
// sqrt_mem_engine: sequential 16-bit integer square-root engine on the
// byte-wide data memory. A falling Start edge reads the operand from
// OP_HI_ADDR/OP_LO_ADDR and computes the 8-bit root one bit per cycle. The
// root is written to RES_ADDR, then Ack is raised.
// Optional feature macro: SQRT_ROUND_EN (round-to-nearest result, saturating
// at 255). The result is floor(sqrt(op)) when the macro is undefined.
module sqrt_mem_engine #(
    parameter logic [7:0] OP_HI_ADDR = 8'd16,
    parameter logic [7:0] OP_LO_ADDR = 8'd17,
    parameter logic [7:0] RES_ADDR   = 8'd18
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic       Busy,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic [7:0] MemWrData,
    output logic       MemWrEn
);

`ifdef SQRT_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_HI = 3'd1,
        RD_LO = 3'd2,
        CALC  = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        start_q_r;

    // Operand is shifted left two bits per iteration so the pair in use is
    // always op_r[15:14].
    logic [15:0] op_r;
    // The remainder fed back between iterations never exceeds 2*root with
    // root < 128, so 8 bits hold it; only the final remainder needs 10 bits,
    // and that one is consumed combinationally by the rounding compare.
    logic [7:0]  rem_r;
    logic [7:0]  root_r;
    logic [2:0]  cnt_r;

    logic [9:0]  rem_shift_s;
    logic [10:0] trial_s;
    logic [9:0]  rem_nxt_s;
    logic [7:0]  root_nxt_s;
    logic        round_up_s;
    logic [7:0]  result_s;

    logic        ack_r;
    logic        busy_r;
    logic [7:0]  mem_addr_r;
    logic [7:0]  mem_wr_data_r;
    logic        mem_wr_en_r;

    logic        ack_nxt_s;
    logic        busy_nxt_s;
    logic [7:0]  mem_addr_nxt_s;
    logic [7:0]  mem_wr_data_nxt_s;
    logic        mem_wr_en_nxt_s;

    assign Ack       = ack_r;
    assign Busy      = busy_r;
    assign MemAddr   = mem_addr_r;
    assign MemWrData = mem_wr_data_r;
    assign MemWrEn   = mem_wr_en_r;

    // State register and Start edge-detect flop.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r   <= IDLE;
            start_q_r <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            start_q_r <= Start;
        end
    end

    // Next-state logic; Start is only looked at in IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_q_r && !Start) begin
                    state_nxt_s = RD_HI;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_HI: state_nxt_s = RD_LO;
            RD_LO: state_nxt_s = CALC;
            CALC: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = WR;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            WR: state_nxt_s = DONE;
            DONE: begin
                if (Start) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // One digit-by-digit root step with an explicit borrow bit, plus the
    // optional round-up of the final result.
    always_comb begin
        rem_shift_s = {rem_r, op_r[15:14]};
        trial_s     = {1'b0, rem_shift_s} - {1'b0, root_r, 2'b01};
        if (!trial_s[10]) begin
            rem_nxt_s  = trial_s[9:0];
            root_nxt_s = {root_r[6:0], 1'b1};
        end else begin
            rem_nxt_s  = rem_shift_s;
            root_nxt_s = {root_r[6:0], 1'b0};
        end
        round_up_s = ROUND_EN && (rem_nxt_s > {2'b00, root_nxt_s})
                     && (root_nxt_s != 8'hFF);
        if (round_up_s) begin
            result_s = root_nxt_s + 8'd1;
        end else begin
            result_s = root_nxt_s;
        end
    end

    // Operand capture and iteration registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            op_r   <= 16'd0;
            rem_r  <= 8'd0;
            root_r <= 8'd0;
            cnt_r  <= 3'd0;
        end else begin
            case (state_r)
                RD_HI: op_r[15:8] <= MemRdData;
                RD_LO: begin
                    op_r[7:0] <= MemRdData;
                    rem_r     <= 8'd0;
                    root_r    <= 8'd0;
                    cnt_r     <= 3'd7;
                end
                CALC: begin
                    op_r   <= {op_r[13:0], 2'b00};
                    rem_r  <= rem_nxt_s[7:0];
                    root_r <= root_nxt_s;
                    cnt_r  <= cnt_r - 3'd1;
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every port is a flop output.
    always_comb begin
        ack_nxt_s         = 1'b0;
        busy_nxt_s        = 1'b0;
        mem_wr_en_nxt_s   = 1'b0;
        mem_addr_nxt_s    = mem_addr_r;
        mem_wr_data_nxt_s = mem_wr_data_r;
        case (state_nxt_s)
            IDLE: ;
            RD_HI: begin
                busy_nxt_s     = 1'b1;
                mem_addr_nxt_s = OP_HI_ADDR;
            end
            RD_LO: begin
                busy_nxt_s     = 1'b1;
                mem_addr_nxt_s = OP_LO_ADDR;
            end
            CALC: busy_nxt_s = 1'b1;
            WR: begin
                busy_nxt_s        = 1'b1;
                mem_addr_nxt_s    = RES_ADDR;
                mem_wr_data_nxt_s = result_s;
                mem_wr_en_nxt_s   = 1'b1;
            end
            DONE: ack_nxt_s = 1'b1;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ack_r         <= 1'b0;
            busy_r        <= 1'b0;
            mem_addr_r    <= 8'd0;
            mem_wr_data_r <= 8'd0;
            mem_wr_en_r   <= 1'b0;
        end else begin
            ack_r         <= ack_nxt_s;
            busy_r        <= busy_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wr_data_r <= mem_wr_data_nxt_s;
            mem_wr_en_r   <= mem_wr_en_nxt_s;
        end
    end

endmodule

// File: tb/tb_sqrt_mem_engine.sv
// Testbench for sqrt_mem_engine: byte memory model, scoreboard queue of
// expected roots, latency/strobe/reset checks. Honours SQRT_ROUND_EN.
module tb_sqrt_mem_engine;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       Busy;
    logic [7:0] MemAddr;
    logic [7:0] MemRdData;
    logic [7:0] MemWrData;
    logic       MemWrEn;

    logic [7:0] mem [0:255];
    int         edge_cnt = 0;
    int         wr_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_q [$];

    sqrt_mem_engine #(
        .OP_HI_ADDR(8'd16),
        .OP_LO_ADDR(8'd17),
        .RES_ADDR  (8'd18)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Ack      (Ack),
        .Busy     (Busy),
        .MemAddr  (MemAddr),
        .MemRdData(MemRdData),
        .MemWrData(MemWrData),
        .MemWrEn  (MemWrEn)
    );

    always #5 Clk = ~Clk;

    assign MemRdData = mem[MemAddr];

    // Memory write port and edge/write counters.
    always @(posedge Clk) begin
        edge_cnt = edge_cnt + 1;
        if (MemWrEn === 1'b1) begin
            mem[MemAddr] = MemWrData;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_root(input int op);
        int r;
        r = 0;
        for (int k = 0; k < 256; k++) begin
            if (k * k <= op) r = k;
        end
`ifdef SQRT_ROUND_EN
        if (((op - r * r) > r) && (r < 255)) r = r + 1;
`endif
        return r;
    endfunction

    // Called and returns right after a negedge, with Start=1 and DUT idle.
    task automatic run_op(input logic [15:0] op, input bit tog);
        int  e;
        int  wr0;
        bit  got;
        int  exp_v;
        mem[16] = op[15:8];
        mem[17] = op[7:0];
        mem[18] = 8'h55;
        exp_q.push_back(model_root(int'(op)));
        wr0   = wr_cnt;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        e = edge_cnt;
        check_val("busy_at_launch", int'(Busy), 1);
        if (tog) begin
            repeat (3) @(negedge Clk);
            Start = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
            @(negedge Clk);
            Start = 1'b1;
            @(negedge Clk);
            check_val("ack_low_in_toggles", int'(Ack), 0);
            Start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge Clk);
            if (Ack === 1'b1) got = 1'b1;
        end
        check_val("ack_seen", int'(got), 1);
        if (got) begin
            check_val("ack_latency", edge_cnt - e, 11);
            check_val("write_pulses", wr_cnt - wr0, 1);
            check_val("busy_after_done", int'(Busy), 0);
            if (exp_q.size() == 0) begin
                check_val("scoreboard_empty", 0, 1);
            end else begin
                exp_v = exp_q.pop_front();
                check_val("result", int'(mem[18]), exp_v);
            end
        end
        Start = 1'b1;
        @(negedge Clk);
        check_val("ack_clear", int'(Ack), 0);
    endtask

    initial begin
        int e;
        int wr0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[18] = 8'h55;
        Reset = 1'b0;
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_val("rst_ack", int'(Ack), 0);
        check_val("rst_busy", int'(Busy), 0);
        check_val("rst_wren", int'(MemWrEn), 0);
        check_val("rst_addr", int'(MemAddr), 0);
        check_val("rst_wdata", int'(MemWrData), 0);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check_val("post_rst_busy", int'(Busy), 0);
        check_val("post_rst_ack", int'(Ack), 0);
        check_val("post_rst_writes", wr_cnt, 0);
        check_val("post_rst_mem18", int'(mem[18]), 8'h55);

        // Main function: 36864 first, then corner operands, back to back.
        run_op(16'd36864, 1'b0);
        run_op(16'd0, 1'b0);
        run_op(16'd1, 1'b0);
        run_op(16'd2, 1'b0);
        run_op(16'd65535, 1'b0);
        run_op(16'd24, 1'b0);
        run_op(16'd1000, 1'b1);
        for (int n = 0; n < 5; n++) begin
            run_op(16'($urandom_range(0, 65535)), 1'b0);
        end

        // Reset asserted during CALC (edge E+5) abandons the run.
        mem[16] = 8'h12;
        mem[17] = 8'h34;
        mem[18] = 8'h55;
        wr0   = wr_cnt;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        e = edge_cnt;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        check_val("abort_edge", edge_cnt - e, 5);
        check_val("abort_busy", int'(Busy), 0);
        check_val("abort_ack", int'(Ack), 0);
        check_val("abort_wren", int'(MemWrEn), 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (20) @(negedge Clk);
        check_val("abort_no_write", wr_cnt - wr0, 0);
        check_val("abort_mem18", int'(mem[18]), 8'h55);
        check_val("abort_ack_idle", int'(Ack), 0);
        check_val("abort_busy_idle", int'(Busy), 0);

        // Engine still works after the abort.
        run_op(16'd144, 1'b0);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
